// File: rtl/dcqcn_cnp_generator_pkg.sv
// Shared DCQCN constants and types for the notification-point CNP generator.
package dcqcn_cnp_generator_pkg;

  localparam int TIME_W             = 16;
  localparam int DCQCN_CNP_INTERVAL = 50;

  typedef struct packed {
    logic              sent;
    logic [TIME_W-1:0] last_t;
  } flow_entry_t;

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dcqcn_cnp_generator_cnp_fifo.sv
// Small synchronous FIFO holding pending CNP flow ids in arrival order.
module cnp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Head is forced to zero when empty so stale storage never shows on the port.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dcqcn_cnp_generator.sv
// DCQCN notification point: per-flow CNP rate limiting on CE-marked arrivals,
// pending CNPs queued toward the tx path.
module dcqcn_cnp_generator
  import dcqcn_cnp_generator_pkg::*;
#(
  parameter int FLOW_NUM     = 16,
  parameter int FLOW_ID_W    = clogb2(FLOW_NUM),
  parameter int CNP_INTERVAL = DCQCN_CNP_INTERVAL,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TIME_W-1:0]    now,
  input  logic                 pkt_valid,
  input  logic [FLOW_ID_W-1:0] pkt_flow_id,
  input  logic                 pkt_ce,
  input  logic                 flow_init,
  input  logic [FLOW_ID_W-1:0] flow_init_id,
  output logic                 cnp_valid,
  output logic [FLOW_ID_W-1:0] cnp_flow_id,
  input  logic                 cnp_ready,
  output logic [15:0]          cnp_sent_cnt,
  output logic [15:0]          cnp_drop_cnt
);

  localparam logic [FLOW_ID_W:0] FLOW_LIM = (FLOW_ID_W+1)'(FLOW_NUM);
  localparam logic [TIME_W-1:0]  INTERVAL = TIME_W'(CNP_INTERVAL);

  flow_entry_t       flow_tbl [FLOW_NUM];
  flow_entry_t       cur_entry;
  logic [TIME_W-1:0] elapsed;
  logic              pkt_id_ok;
  logic              init_ok;
  logic              init_hit;
  logic              qualified;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              space;
  logic              push;
  logic              drop;

  assign pkt_id_ok = ({1'b0, pkt_flow_id} < FLOW_LIM);
  assign init_ok   = flow_init & ({1'b0, flow_init_id} < FLOW_LIM);
  assign init_hit  = init_ok & (flow_init_id == pkt_flow_id);

  assign cur_entry = flow_tbl[pkt_flow_id];
  // Modular subtraction keeps the spacing check correct across `now` wrap.
  assign elapsed   = now - cur_entry.last_t;

  assign qualified = pkt_valid & pkt_id_ok & pkt_ce & ~init_hit &
                     (~cur_entry.sent | (elapsed >= INTERVAL));

  assign cnp_valid = ~fifo_empty;
  assign pop       = cnp_valid & cnp_ready;
  assign space     = ~fifo_full | pop;
  assign push      = qualified & space;
  assign drop      = qualified & ~space;

  // A dropped CNP leaves the entry untouched so the next CE mark can retry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FLOW_NUM; i++) flow_tbl[i] <= '0;
    end else begin
      for (int i = 0; i < FLOW_NUM; i++) begin
        if (init_ok && (flow_init_id == FLOW_ID_W'(i))) begin
          flow_tbl[i] <= '0;
        end else if (push && (pkt_flow_id == FLOW_ID_W'(i))) begin
          flow_tbl[i] <= '{sent: 1'b1, last_t: now};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnp_sent_cnt <= '0;
      cnp_drop_cnt <= '0;
    end else begin
      if (pop)  cnp_sent_cnt <= cnp_sent_cnt + 16'd1;
      if (drop) cnp_drop_cnt <= cnp_drop_cnt + 16'd1;
    end
  end

  cnp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FLOW_ID_W)
  ) u_cnp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (pkt_flow_id),
    .pop       (pop),
    .pop_data  (cnp_flow_id),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_dcqcn_cnp_generator.sv
// Directed bench for dcqcn_cnp_generator with a queue-based reference model.
module tb_dcqcn_cnp_generator;

  localparam int DEPTH = 4;
  localparam int IVL   = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] now = '0;
  logic        pkt_valid = 1'b0;
  logic [3:0]  pkt_flow_id = '0;
  logic        pkt_ce = 1'b0;
  logic        flow_init = 1'b0;
  logic [3:0]  flow_init_id = '0;
  logic        cnp_valid;
  logic [3:0]  cnp_flow_id;
  logic        cnp_ready = 1'b0;
  logic [15:0] cnp_sent_cnt;
  logic [15:0] cnp_drop_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_sent [16];
  bit [15:0]   m_last [16];
  int          mq [$];
  bit [15:0]   m_sent_cnt = '0;
  bit [15:0]   m_drop_cnt = '0;

  dcqcn_cnp_generator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .now          (now),
    .pkt_valid    (pkt_valid),
    .pkt_flow_id  (pkt_flow_id),
    .pkt_ce       (pkt_ce),
    .flow_init    (flow_init),
    .flow_init_id (flow_init_id),
    .cnp_valid    (cnp_valid),
    .cnp_flow_id  (cnp_flow_id),
    .cnp_ready    (cnp_ready),
    .cnp_sent_cnt (cnp_sent_cnt),
    .cnp_drop_cnt (cnp_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_sent[i] = 1'b0;
      m_last[i] = '0;
    end
    mq.delete();
    m_sent_cnt = '0;
    m_drop_cnt = '0;
  endtask

  always @(negedge rst_n) model_reset();

  // Model advances on each edge from the stable inputs, then the DUT is compared.
  always @(posedge clk) begin
    bit        pop, space, qual, same;
    bit [15:0] gap;
    if (!rst_n) begin
      model_reset();
    end else begin
      pop   = (mq.size() != 0) && cnp_ready;
      space = (mq.size() < DEPTH) || pop;
      same  = flow_init && (flow_init_id == pkt_flow_id);
      gap   = now - m_last[pkt_flow_id];
      qual  = pkt_valid && pkt_ce && !same &&
              (!m_sent[pkt_flow_id] || gap >= 16'(IVL));
      if (flow_init) begin
        m_sent[flow_init_id] = 1'b0;
        m_last[flow_init_id] = '0;
      end
      if (pop) begin
        void'(mq.pop_front());
        m_sent_cnt++;
      end
      if (qual && space) begin
        mq.push_back(int'(pkt_flow_id));
        m_sent[pkt_flow_id] = 1'b1;
        m_last[pkt_flow_id] = now;
      end else if (qual) begin
        m_drop_cnt++;
      end
    end
    #1;
    chk("model_valid", 32'(cnp_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("model_flow_id", 32'(cnp_flow_id), 32'(mq[0]));
    else                chk("model_flow_id_idle", 32'(cnp_flow_id), 32'd0);
    chk("model_sent_cnt", 32'(cnp_sent_cnt), 32'(m_sent_cnt));
    chk("model_drop_cnt", 32'(cnp_drop_cnt), 32'(m_drop_cnt));
  end

  task automatic step(input bit pv, input int fid, input bit ce, input int t,
                      input bit ini, input int iid, input bit rdy);
    @(negedge clk);
    pkt_valid    = pv;
    pkt_flow_id  = 4'(fid);
    pkt_ce       = ce;
    now          = 16'(t);
    flow_init    = ini;
    flow_init_id = 4'(iid);
    cnp_ready    = rdy;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 0, 1'b0, int'(now), 1'b0, 0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pkt_valid = 1'b0;
    flow_init = 1'b0;
    cnp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("reset_valid", 32'(cnp_valid), 32'd0);
    chk("reset_flow_id", 32'(cnp_flow_id), 32'd0);
    chk("reset_sent", 32'(cnp_sent_cnt), 32'd0);
    chk("reset_drop", 32'(cnp_drop_cnt), 32'd0);

    // 1: first CE on flow 3 produces a CNP one cycle later
    step(1'b1, 3, 1'b1, 100, 1'b0, 0, 1'b0);
    idle(1'b0);
    chk("t1_valid", 32'(cnp_valid), 32'd1);
    chk("t1_flow_id", 32'(cnp_flow_id), 32'd3);

    // 2: rate limiting within CNP_INTERVAL
    do_reset();
    step(1'b1, 3, 1'b1, 100, 1'b0, 0, 1'b1);
    idle(1'b1);
    step(1'b1, 3, 1'b1, 120, 1'b0, 0, 1'b1);
    idle(1'b1);
    step(1'b1, 3, 1'b1, 150, 1'b0, 0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("t2_sent_cnt", 32'(cnp_sent_cnt), 32'd2);
    // spacing boundary: 49 rejected, 50 accepted
    step(1'b1, 5, 1'b1, 1000, 1'b0, 0, 1'b1);
    step(1'b1, 5, 1'b1, 1049, 1'b0, 0, 1'b1);
    step(1'b1, 5, 1'b1, 1050, 1'b0, 0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("t2_boundary_sent", 32'(cnp_sent_cnt), 32'd4);
    // non-CE packet has no effect
    step(1'b1, 6, 1'b0, 1100, 1'b0, 0, 1'b1);
    idle(1'b1);
    chk("t2_nonce_valid", 32'(cnp_valid), 32'd0);

    // 3: FIFO overflow drops, order preserved, dropped flow retries
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, i, 1'b1, 200 + i, 1'b0, 0, 1'b0);
    idle(1'b0);
    chk("t3_drop_cnt", 32'(cnp_drop_cnt), 32'd2);
    chk("t3_head_hold", 32'(cnp_flow_id), 32'd0);
    idle(1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("t3_pop_order", 32'(cnp_flow_id), 32'(k));
      if (k < 3) idle(1'b1);
    end
    step(1'b1, 4, 1'b1, 207, 1'b0, 0, 1'b1);
    idle(1'b1);
    chk("t3_retry_valid", 32'(cnp_valid), 32'd1);
    chk("t3_retry_flow", 32'(cnp_flow_id), 32'd4);

    // 4: elapsed time across `now` wrap
    do_reset();
    step(1'b1, 2, 1'b1, 65526, 1'b0, 0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    step(1'b1, 2, 1'b1, 45, 1'b0, 0, 1'b1);
    idle(1'b1);
    chk("t4_wrap_valid", 32'(cnp_valid), 32'd1);
    chk("t4_wrap_flow", 32'(cnp_flow_id), 32'd2);

    // 5: init wins on same flow; differing flows both act
    do_reset();
    step(1'b1, 7, 1'b1, 300, 1'b1, 7, 1'b1);
    idle(1'b1);
    chk("t5_init_block", 32'(cnp_valid), 32'd0);
    step(1'b1, 7, 1'b1, 301, 1'b0, 0, 1'b1);
    idle(1'b1);
    chk("t5_after_init_valid", 32'(cnp_valid), 32'd1);
    chk("t5_after_init_flow", 32'(cnp_flow_id), 32'd7);
    step(1'b1, 9, 1'b1, 302, 1'b1, 7, 1'b1);
    step(1'b1, 7, 1'b1, 303, 1'b0, 0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("t5_diff_flows_sent", 32'(cnp_sent_cnt), 32'd3);

    // 6: asynchronous reset discards queued CNPs
    for (int i = 8; i < 11; i++) step(1'b1, i, 1'b1, 400, 1'b0, 0, 1'b0);
    idle(1'b0);
    chk("t6_queued", 32'(cnp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(cnp_valid), 32'd0);
    chk("t6_async_sent", 32'(cnp_sent_cnt), 32'd0);
    chk("t6_async_drop", 32'(cnp_drop_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8, 1'b1, 401, 1'b0, 0, 1'b0);
    idle(1'b0);
    chk("t6_fresh_flow", 32'(cnp_flow_id), 32'd8);
    idle(1'b1);
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
